apb_requester: RTL and testbench
================================

# apb_requester

APB4 requester (master) that turns single-word commands from a local valid/ready port into APB setup/access transfers and returns read data and error status on a response port. It is the initiating end of the same APB bus the UART register block serves. It drives `psel`/`penable`/`paddr`/`pwdata`/`pwrite`/`pstrb` and samples `pready`/`prdata`/`pslverr`. A wait-state timeout keeps the requester from hanging on a completer that never asserts `pready`.

## Interface
- `ADDR_W`, 12: APB address width.
- `DATA_W`, 32: data width; `DATA_W/8` strobe lanes.
- `TIMEOUT`, 255: maximum ACCESS cycles with `pready` low before abort. A value of 0 disables the timeout.

- `clk`  in  1: single clock; the APB bus runs on this clock.
- `reset_n`  in  1: asynchronous, active-low reset.
- `cmd_valid`  in  1: command present.
- `cmd_ready`  out  1: requester can accept a command.
- `cmd_write`  in  1: 1 = write, 0 = read.
- `cmd_addr`  in  ADDR_W: target address.
- `cmd_wdata`  in  DATA_W: write data.
- `cmd_strb`  in  DATA_W/8: write byte strobes.
- `rsp_valid`  out  1: response present.
- `rsp_ready`  in  1: response consumer ready.
- `rsp_rdata`  out  DATA_W: read data; 0 for writes and on timeout.
- `rsp_err`  out  1: `pslverr` was sampled high, or the transfer timed out.
- `rsp_timeout`  out  1: the transfer was aborted by the timeout.
- `psel`, `penable`, `pwrite`  out  1: APB control.
- `paddr`  out  ADDR_W: APB address.
- `pwdata`  out  DATA_W: APB write data.
- `pstrb`  out  DATA_W/8: APB write strobes.
- `pready`, `pslverr`  in  1: APB completer status.
- `prdata`  in  DATA_W: APB read data.

## Operation
- State machine with four states: IDLE, SETUP, ACCESS, RESP. All outputs are registered.
- IDLE:
  - `cmd_ready`=1.
  - When `cmd_valid` is high, capture `cmd_write`/`cmd_addr`/`cmd_wdata` into `pwrite`/`paddr`/`pwdata`, and capture `cmd_strb` into `pstrb`.
  - On a read, force `pstrb` to 0.
  - Clear the wait counter and go to SETUP.
- SETUP: `psel`=1, `penable`=0, `cmd_ready`=0. Always advance to ACCESS after exactly one cycle.
- ACCESS:
  - `psel`=1, `penable`=1.
  - On `pready`=1:
    - Sample `prdata` into `rsp_rdata`; writes load 0 instead.
    - Sample `pslverr` into `rsp_err`.
    - Set `rsp_timeout`=0 and go to RESP.
  - On `pready`=0: increment the wait counter, which saturates.
  - Timeout abort:
    - Triggers when `TIMEOUT`≠0 and the counter equals `TIMEOUT` in a cycle with `pready`=0.
    - Set `rsp_err`=1, `rsp_timeout`=1, `rsp_rdata`=0, and go to RESP.
- RESP:
  - `psel`=0, `penable`=0, `rsp_valid`=1.
  - Response fields stay stable until `rsp_ready`=1, then return to IDLE.
- Outside SETUP/ACCESS, `paddr`/`pwdata`/`pwrite`/`pstrb` hold their last values. `psel`=0 and `penable`=0.
- Wait counter width is `$clog2(TIMEOUT+1)`, minimum 1 bit.
- Reset (asynchronous, any state):
  - State returns to IDLE and the counter clears.
  - All outputs return to 0, except `cmd_ready`, which is 1 once `reset_n` is high.
  - A transfer cut by reset is dropped and produces no response.

## Timing
- Command accepted at edge E0:
  - SETUP visible in cycle E0..E1.
  - ACCESS visible from E1.
  - With zero wait states, `pready` is sampled at E2 and `rsp_valid` goes high after E2.
- Each `pready`-low cycle adds one cycle of latency.
- A timeout aborts at the edge where the `TIMEOUT`-th consecutive low-`pready` ACCESS cycle ends: `psel` has been high for `TIMEOUT`+1 cycles.
- `cmd_ready` is high only in IDLE. Minimum spacing is 4 cycles per transfer with `rsp_ready` held at 1.
- `paddr`, `pwrite`, `pwdata` and `pstrb` are stable from SETUP through the final ACCESS cycle (APB4 rule).
- `rsp_ready` may be high before `rsp_valid`; the response is consumed on the first cycle in RESP.
- `cmd_valid` seen outside IDLE is ignored. The command source must hold it until `cmd_ready`.

## Test plan
- Write: `cmd_addr`=0x004, `cmd_wdata`=0xA5A5_0055, `cmd_strb`=0xF, zero-wait completer.
  - `psel` rises one cycle after acceptance; `penable` rises one cycle later.
  - The completer sees the write.
  - `rsp_valid` appears 3 cycles after acceptance with `rsp_err`=0 and `rsp_rdata`=0.
- Read with 3 wait states: `prdata`=0x0000_1234 presented with `pready`.
  - `penable` stays high for 4 cycles.
  - `rsp_rdata`=0x1234 and `pstrb`=0 throughout.
- `pslverr`=1 on a write to 0x3FC: `rsp_err`=1, `rsp_timeout`=0, and the bus returns to idle in RESP.
- Timeout with `TIMEOUT`=4 and `pready` tied low:
  - The transfer aborts after 4 ACCESS cycles.
  - `rsp_err`=1, `rsp_timeout`=1, `rsp_rdata`=0.
  - A following command completes normally.
- Backpressure and reset:
  - Hold `rsp_ready`=0 for 10 cycles: the response stays stable and no new command is accepted.
  - Separately, assert `reset_n`=0 mid-ACCESS: `psel`/`penable` drop immediately, no response is produced, and `cmd_ready`=1 after release.

Source files
------------

// File: rtl/apb_requester.sv
`default_nettype none
// ============================================================================
// Module   : apb_requester
// Brief    : APB4 requester turning valid/ready commands into APB transfers,
//            with a wait-state timeout and a valid/ready response port.
// Revision : 1.0 - initial release
// ============================================================================

module apb_requester #(
    parameter int ADDR_W  = 12,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_write,
    input  logic [ADDR_W-1:0]   cmd_addr,
    input  logic [DATA_W-1:0]   cmd_wdata,
    input  logic [DATA_W/8-1:0] cmd_strb,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_err,
    output logic                rsp_timeout,
    output logic                psel,
    output logic                penable,
    output logic                pwrite,
    output logic [ADDR_W-1:0]   paddr,
    output logic [DATA_W-1:0]   pwdata,
    output logic [DATA_W/8-1:0] pstrb,
    input  logic                pready,
    input  logic                pslverr,
    input  logic [DATA_W-1:0]   prdata
);

    localparam int STRB_W = DATA_W / 8;
    localparam int CNT_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [CNT_W-1:0] c_timeout = CNT_W'(TIMEOUT);
    localparam logic [1:0]       c_idle    = 2'd0;
    localparam logic [1:0]       c_setup   = 2'd1;
    localparam logic [1:0]       c_access  = 2'd2;
    localparam logic [1:0]       c_resp    = 2'd3;

    logic [1:0]        r_state,       w_state_nxt;
    logic [CNT_W-1:0]  r_cnt,         w_cnt_nxt;
    logic              r_cmd_ready,   w_cmd_ready_nxt;
    logic              r_psel,        w_psel_nxt;
    logic              r_penable,     w_penable_nxt;
    logic              r_pwrite,      w_pwrite_nxt;
    logic [ADDR_W-1:0] r_paddr,       w_paddr_nxt;
    logic [DATA_W-1:0] r_pwdata,      w_pwdata_nxt;
    logic [STRB_W-1:0] r_pstrb,       w_pstrb_nxt;
    logic              r_rsp_valid,   w_rsp_valid_nxt;
    logic [DATA_W-1:0] r_rsp_rdata,   w_rsp_rdata_nxt;
    logic              r_rsp_err,     w_rsp_err_nxt;
    logic              r_rsp_timeout, w_rsp_timeout_nxt;

    logic [CNT_W-1:0]  w_cnt_inc;
    logic              w_abort;

    // The compare uses the post-increment count, so the abort lands at the end
    // of the TIMEOUT-th consecutive low-pready ACCESS cycle.
    assign w_cnt_inc = (&r_cnt) ? r_cnt : r_cnt + 1'b1;
    assign w_abort   = (TIMEOUT != 0) && (w_cnt_inc == c_timeout);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= c_idle;
            r_cnt         <= '0;
            r_cmd_ready   <= 1'b1;
            r_psel        <= 1'b0;
            r_penable     <= 1'b0;
            r_pwrite      <= 1'b0;
            r_paddr       <= '0;
            r_pwdata      <= '0;
            r_pstrb       <= '0;
            r_rsp_valid   <= 1'b0;
            r_rsp_rdata   <= '0;
            r_rsp_err     <= 1'b0;
            r_rsp_timeout <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_cnt         <= w_cnt_nxt;
            r_cmd_ready   <= w_cmd_ready_nxt;
            r_psel        <= w_psel_nxt;
            r_penable     <= w_penable_nxt;
            r_pwrite      <= w_pwrite_nxt;
            r_paddr       <= w_paddr_nxt;
            r_pwdata      <= w_pwdata_nxt;
            r_pstrb       <= w_pstrb_nxt;
            r_rsp_valid   <= w_rsp_valid_nxt;
            r_rsp_rdata   <= w_rsp_rdata_nxt;
            r_rsp_err     <= w_rsp_err_nxt;
            r_rsp_timeout <= w_rsp_timeout_nxt;
        end
    end

    always_comb begin
        w_state_nxt       = r_state;
        w_cnt_nxt         = r_cnt;
        w_cmd_ready_nxt   = r_cmd_ready;
        w_psel_nxt        = r_psel;
        w_penable_nxt     = r_penable;
        w_pwrite_nxt      = r_pwrite;
        w_paddr_nxt       = r_paddr;
        w_pwdata_nxt      = r_pwdata;
        w_pstrb_nxt       = r_pstrb;
        w_rsp_valid_nxt   = r_rsp_valid;
        w_rsp_rdata_nxt   = r_rsp_rdata;
        w_rsp_err_nxt     = r_rsp_err;
        w_rsp_timeout_nxt = r_rsp_timeout;

        case (r_state)
            c_idle: begin
                if (cmd_valid) begin
                    w_pwrite_nxt    = cmd_write;
                    w_paddr_nxt     = cmd_addr;
                    w_pwdata_nxt    = cmd_wdata;
                    w_pstrb_nxt     = cmd_write ? cmd_strb : '0;
                    w_cnt_nxt       = '0;
                    w_psel_nxt      = 1'b1;
                    w_cmd_ready_nxt = 1'b0;
                    w_state_nxt     = c_setup;
                end
            end
            c_setup: begin
                w_penable_nxt = 1'b1;
                w_state_nxt   = c_access;
            end
            c_access: begin
                if (pready) begin
                    w_rsp_rdata_nxt   = r_pwrite ? '0 : prdata;
                    w_rsp_err_nxt     = pslverr;
                    w_rsp_timeout_nxt = 1'b0;
                    w_rsp_valid_nxt   = 1'b1;
                    w_psel_nxt        = 1'b0;
                    w_penable_nxt     = 1'b0;
                    w_state_nxt       = c_resp;
                end else if (w_abort) begin
                    w_rsp_rdata_nxt   = '0;
                    w_rsp_err_nxt     = 1'b1;
                    w_rsp_timeout_nxt = 1'b1;
                    w_rsp_valid_nxt   = 1'b1;
                    w_psel_nxt        = 1'b0;
                    w_penable_nxt     = 1'b0;
                    w_state_nxt       = c_resp;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            c_resp: begin
                if (rsp_ready) begin
                    w_rsp_valid_nxt = 1'b0;
                    w_cmd_ready_nxt = 1'b1;
                    w_state_nxt     = c_idle;
                end
            end
            default: begin
                w_psel_nxt      = 1'b0;
                w_penable_nxt   = 1'b0;
                w_rsp_valid_nxt = 1'b0;
                w_cmd_ready_nxt = 1'b1;
                w_state_nxt     = c_idle;
            end
        endcase
    end

    assign cmd_ready   = r_cmd_ready;
    assign psel        = r_psel;
    assign penable     = r_penable;
    assign pwrite      = r_pwrite;
    assign paddr       = r_paddr;
    assign pwdata      = r_pwdata;
    assign pstrb       = r_pstrb;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_rdata   = r_rsp_rdata;
    assign rsp_err     = r_rsp_err;
    assign rsp_timeout = r_rsp_timeout;

endmodule

`default_nettype wire

// File: tb/tb_apb_requester.sv
`default_nettype none
// ============================================================================
// Module   : tb_apb_requester
// Brief    : Self-checking bench for apb_requester with a scripted completer.
// Revision : 1.0 - initial release
// ============================================================================

module tb_apb_requester;

    localparam int TB_TIMEOUT = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
    logic [11:0] cmd_addr = '0;
    logic [31:0] cmd_wdata = '0;
    logic [3:0]  cmd_strb = '0;
    logic        rsp_valid, rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_err, rsp_timeout;
    logic        psel, penable, pwrite;
    logic [11:0] paddr;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic        pready = 1'b0, pslverr = 1'b0;
    logic [31:0] prdata = '0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Observations of the most recent transfer
    bit          obs_hung, obs_setup_ok, obs_stable, obs_rdy_low, obs_rsp_stable;
    int          obs_psel, obs_pen, obs_lat, obs_accept_cyc;
    logic        obs_write, obs_err, obs_to;
    logic [11:0] obs_addr;
    logic [31:0] obs_wdata, obs_rdata;
    logic [3:0]  obs_strb;
    logic [1:0]  obs_rsp_bus;
    logic [2:0]  obs_after;

    typedef struct packed {
        int          access;
        logic [31:0] rdata;
        logic        err;
        logic        to;
        logic [3:0]  strb;
    } exp_t;

    apb_requester #(.ADDR_W(12), .DATA_W(32), .TIMEOUT(TB_TIMEOUT)) dut (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
        .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
        .pwdata(pwdata), .pstrb(pstrb),
        .pready(pready), .pslverr(pslverr), .prdata(prdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference: a completer answering after `waits` low cycles, against the timeout rule
    function automatic exp_t model(input bit wr, input logic [3:0] s, input int waits,
                                   input logic [31:0] rd, input bit se);
        exp_t e;
        if (TB_TIMEOUT != 0 && waits >= TB_TIMEOUT) begin
            e.access = TB_TIMEOUT; e.rdata = '0; e.err = 1'b1; e.to = 1'b1;
        end else begin
            e.access = waits + 1; e.rdata = wr ? 32'h0 : rd; e.err = se; e.to = 1'b0;
        end
        e.strb = wr ? s : 4'h0;
        return e;
    endfunction

    // Drives one command and plays the completer; caller must be at a negedge.
    task automatic run_xfer(input bit wr, input logic [11:0] a, input logic [31:0] d,
                            input logic [3:0] s, input int waits, input logic [31:0] rd,
                            input bit se, input int hold);
        int  t;
        bit  done;
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_strb = s;
        rsp_ready = (hold == 0);
        obs_hung = 1'b0; obs_setup_ok = 1'b0; obs_stable = 1'b1; obs_rdy_low = 1'b1;
        obs_rsp_stable = 1'b1; obs_psel = 0; obs_pen = 0; obs_lat = 0; obs_after = '0;
        t = 0;
        while (!cmd_ready && t < 20) begin @(negedge clk); t++; end
        if (!cmd_ready) begin obs_hung = 1'b1; cmd_valid = 1'b0; return; end
        obs_accept_cyc = cyc;
        @(negedge clk);
        cmd_valid = 1'b0; cmd_write = 1'($urandom); cmd_addr = 12'($urandom);
        cmd_wdata = $urandom; cmd_strb = 4'($urandom);
        done = 1'b0;
        for (t = 1; t <= 60 && !done; t++) begin
            if (rsp_valid) begin
                done = 1'b1; obs_lat = t;
                obs_rdata = rsp_rdata; obs_err = rsp_err; obs_to = rsp_timeout;
                obs_rsp_bus = {psel, penable};
            end else begin
                if (psel) obs_psel++;
                if (penable) obs_pen++;
                if (cmd_ready) obs_rdy_low = 1'b0;
                if (t == 1) begin
                    obs_setup_ok = psel && !penable;
                    obs_write = pwrite; obs_addr = paddr; obs_wdata = pwdata; obs_strb = pstrb;
                end else if (psel && {pwrite, paddr, pwdata, pstrb} !== {obs_write, obs_addr, obs_wdata, obs_strb}) begin
                    obs_stable = 1'b0;
                end
                pready  = (t >= 2 && t == waits + 2);
                prdata  = pready ? rd : $urandom;
                pslverr = pready ? se : 1'($urandom);
                @(negedge clk);
            end
        end
        pready = 1'b0; pslverr = 1'b0;
        if (!done) begin obs_hung = 1'b1; return; end
        for (int h = 0; h < hold; h++) begin
            cmd_valid = 1'b1; cmd_addr = 12'($urandom); cmd_write = 1'($urandom);
            @(negedge clk);
            if (!rsp_valid || {rsp_rdata, rsp_err, rsp_timeout} !== {obs_rdata, obs_err, obs_to}
                || psel || cmd_ready)
                obs_rsp_stable = 1'b0;
        end
        cmd_valid = 1'b0; rsp_ready = 1'b1;
        @(negedge clk);
        obs_after = {rsp_valid, cmd_ready, psel};
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({cmd_ready, psel, penable, pwrite, paddr, pwdata, pstrb, rsp_valid, rsp_rdata, rsp_err, rsp_timeout}
            !== {1'b1, 3'b000, 12'h0, 32'h0, 4'h0, 1'b0, 32'h0, 2'b00}) begin
            errors++;
            $display("FAIL reset_state: got rdy=%b sel=%b en=%b wr=%b a=%h d=%h s=%h rv=%b rd=%h e=%b to=%b, required rdy=1 and all others 0",
                     cmd_ready, psel, penable, pwrite, paddr, pwdata, pstrb, rsp_valid, rsp_rdata, rsp_err, rsp_timeout);
        end
    endtask

    task automatic test_write;
        exp_t e;
        e = model(1'b1, 4'hF, 0, 32'h0, 1'b0);
        run_xfer(1'b1, 12'h004, 32'hA5A5_0055, 4'hF, 0, 32'hDEAD_BEEF, 1'b0, 0);
        checks++;
        if ({obs_hung, obs_setup_ok, obs_psel, obs_pen} !== {1'b0, 1'b1, e.access + 1, e.access}) begin
            errors++;
            $display("FAIL write_phases: got hung=%b setup=%b psel_cyc=%0d pen_cyc=%0d, required 0 1 %0d %0d",
                     obs_hung, obs_setup_ok, obs_psel, obs_pen, e.access + 1, e.access);
        end
        checks++;
        if (obs_lat !== 3) begin
            errors++; $display("FAIL write_latency: got %0d cycles, required 3", obs_lat);
        end
        checks++;
        if ({obs_write, obs_addr, obs_wdata, obs_strb, obs_stable} !== {1'b1, 12'h004, 32'hA5A5_0055, 4'hF, 1'b1}) begin
            errors++;
            $display("FAIL write_bus: got w=%b a=%h d=%h s=%h stable=%b, required 1 004 a5a50055 f 1",
                     obs_write, obs_addr, obs_wdata, obs_strb, obs_stable);
        end
        checks++;
        if ({obs_rdata, obs_err, obs_to, obs_after} !== {32'h0, 2'b00, 3'b010}) begin
            errors++;
            $display("FAIL write_rsp: got rd=%h err=%b to=%b after=%b, required 0 0 0 010",
                     obs_rdata, obs_err, obs_to, obs_after);
        end
    endtask

    task automatic test_read_wait;
        run_xfer(1'b0, 12'h010, 32'hFFFF_FFFF, 4'hF, 3, 32'h0000_1234, 1'b0, 0);
        checks++;
        if ({obs_psel, obs_pen, obs_lat} !== {32'd5, 32'd4, 32'd6}) begin
            errors++;
            $display("FAIL read_wait_timing: got psel_cyc=%0d pen_cyc=%0d lat=%0d, required 5 4 6",
                     obs_psel, obs_pen, obs_lat);
        end
        checks++;
        if ({obs_write, obs_strb, obs_stable} !== {1'b0, 4'h0, 1'b1}) begin
            errors++;
            $display("FAIL read_wait_strb: got w=%b s=%h stable=%b, required 0 0 1", obs_write, obs_strb, obs_stable);
        end
        checks++;
        if ({obs_rdata, obs_err, obs_to} !== {32'h0000_1234, 2'b00}) begin
            errors++;
            $display("FAIL read_wait_rsp: got rd=%h err=%b to=%b, required 00001234 0 0", obs_rdata, obs_err, obs_to);
        end
    endtask

    task automatic test_slverr;
        run_xfer(1'b1, 12'h3FC, 32'h1111_2222, 4'h3, 1, 32'h5555_5555, 1'b1, 0);
        checks++;
        if ({obs_err, obs_to, obs_rdata} !== {2'b10, 32'h0}) begin
            errors++;
            $display("FAIL slverr_rsp: got err=%b to=%b rd=%h, required 1 0 0", obs_err, obs_to, obs_rdata);
        end
        checks++;
        if ({obs_rsp_bus, obs_after} !== {2'b00, 3'b010}) begin
            errors++;
            $display("FAIL slverr_bus_idle: got sel/en=%b after=%b, required 00 010", obs_rsp_bus, obs_after);
        end
    endtask

    task automatic test_timeout;
        run_xfer(1'b0, 12'h020, 32'h0, 4'hF, 1000, 32'hCAFE_F00D, 1'b0, 0);
        checks++;
        if ({obs_psel, obs_pen, obs_lat} !== {TB_TIMEOUT + 1, TB_TIMEOUT, TB_TIMEOUT + 2}) begin
            errors++;
            $display("FAIL timeout_timing: got psel_cyc=%0d pen_cyc=%0d lat=%0d, required %0d %0d %0d",
                     obs_psel, obs_pen, obs_lat, TB_TIMEOUT + 1, TB_TIMEOUT, TB_TIMEOUT + 2);
        end
        checks++;
        if ({obs_err, obs_to, obs_rdata, obs_rsp_bus} !== {2'b11, 32'h0, 2'b00}) begin
            errors++;
            $display("FAIL timeout_rsp: got err=%b to=%b rd=%h sel/en=%b, required 1 1 0 00",
                     obs_err, obs_to, obs_rdata, obs_rsp_bus);
        end
        run_xfer(1'b0, 12'h024, 32'h0, 4'hF, 2, 32'h0BAD_CAFE, 1'b0, 0);
        checks++;
        if ({obs_hung, obs_rdata, obs_err, obs_to, obs_lat} !== {1'b0, 32'h0BAD_CAFE, 2'b00, 32'd5}) begin
            errors++;
            $display("FAIL timeout_followup: got hung=%b rd=%h err=%b to=%b lat=%0d, required 0 0badcafe 0 0 5",
                     obs_hung, obs_rdata, obs_err, obs_to, obs_lat);
        end
    endtask

    task automatic test_backpressure;
        run_xfer(1'b0, 12'h040, 32'h0, 4'h0, 0, 32'h7777_8888, 1'b0, 10);
        checks++;
        if ({obs_rsp_stable, obs_rdata} !== {1'b1, 32'h7777_8888}) begin
            errors++;
            $display("FAIL backpressure_hold: got stable=%b rd=%h, required 1 77778888", obs_rsp_stable, obs_rdata);
        end
        checks++;
        if (obs_after !== 3'b010) begin
            errors++; $display("FAIL backpressure_release: got after=%b, required 010", obs_after);
        end
    endtask

    task automatic test_back_to_back;
        int first;
        run_xfer(1'b1, 12'h100, 32'h1, 4'h1, 0, 32'h0, 1'b0, 0);
        first = obs_accept_cyc;
        run_xfer(1'b1, 12'h104, 32'h2, 4'h2, 0, 32'h0, 1'b0, 0);
        checks++;
        if (obs_accept_cyc - first !== 4) begin
            errors++; $display("FAIL back_to_back_spacing: got %0d cycles, required 4", obs_accept_cyc - first);
        end
    endtask

    task automatic test_reset_mid_access;
        bit seen;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 12'h200; rsp_ready = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        pready = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({psel, penable} !== 2'b11) begin
            errors++; $display("FAIL reset_mid_in_access: got sel/en=%b, required 11", {psel, penable});
        end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if ({psel, penable, rsp_valid} !== 3'b000) begin
            errors++; $display("FAIL reset_mid_drop: got sel/en/rv=%b, required 000", {psel, penable, rsp_valid});
        end
        @(negedge clk);
        reset_n = 1'b1;
        seen = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (rsp_valid || psel || !cmd_ready) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++; $display("FAIL reset_mid_after: got spurious activity=%b, required 0 (idle, ready)", seen);
        end
    endtask

    task automatic test_random;
        bit          wr, se;
        logic [11:0] a;
        logic [31:0] d, rd;
        logic [3:0]  s;
        int          waits, hold;
        exp_t        e;
        for (int i = 0; i < 30; i++) begin
            wr = 1'($urandom); se = ($urandom_range(0, 3) == 0);
            a = 12'($urandom); d = $urandom; rd = $urandom; s = 4'($urandom);
            waits = ($urandom_range(0, 6) == 0) ? $urandom_range(4, 7) : $urandom_range(0, 3);
            hold = $urandom_range(0, 2);
            e = model(wr, s, waits, rd, se);
            run_xfer(wr, a, d, s, waits, rd, se, hold);
            checks++;
            if ({obs_hung, obs_setup_ok, obs_psel, obs_pen, obs_lat, obs_rdy_low}
                !== {1'b0, 1'b1, e.access + 1, e.access, e.access + 2, 1'b1}) begin
                errors++;
                $display("FAIL rand_timing[%0d]: got hung=%b setup=%b psel=%0d pen=%0d lat=%0d rdylow=%b, required 0 1 %0d %0d %0d 1",
                         i, obs_hung, obs_setup_ok, obs_psel, obs_pen, obs_lat, obs_rdy_low,
                         e.access + 1, e.access, e.access + 2);
            end
            checks++;
            if ({obs_rdata, obs_err, obs_to, obs_rsp_bus} !== {e.rdata, e.err, e.to, 2'b00}) begin
                errors++;
                $display("FAIL rand_rsp[%0d]: got rd=%h err=%b to=%b sel/en=%b, required %h %b %b 00",
                         i, obs_rdata, obs_err, obs_to, obs_rsp_bus, e.rdata, e.err, e.to);
            end
            checks++;
            if ({obs_write, obs_addr, obs_wdata, obs_strb, obs_stable, obs_rsp_stable, obs_after}
                !== {wr, a, d, e.strb, 2'b11, 3'b010}) begin
                errors++;
                $display("FAIL rand_bus[%0d]: got w=%b a=%h d=%h s=%h stab=%b rstab=%b after=%b, required %b %h %h %h 1 1 010",
                         i, obs_write, obs_addr, obs_wdata, obs_strb, obs_stable, obs_rsp_stable, obs_after,
                         wr, a, d, e.strb);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_write();
        test_read_wait();
        test_slverr();
        test_timeout();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_access();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
